word_ram_writer: RTL and testbench

WORD_RAM_WRITER -- requirements
Module: word_ram_writer

---
 rtl/word_mem_pkg.sv | 20 ++
 rtl/word_mem_array.sv | 55 +++++
 rtl/word_ram_writer.sv | 110 +++++++++++
 tb/tb_word_ram_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/word_mem_pkg.sv
// -----------------------------------------------------------------------------
// word_mem_pkg
// Shared definitions for the word store blocks: the writer FSM state
// encoding and the default geometry (DEPTH words of WIDTH bits, AW-bit
// addresses and counts). The read-only store uses the same defaults.
// No ports (package).
// -----------------------------------------------------------------------------
package word_mem_pkg;

    localparam int DEF_DEPTH = 10;
    localparam int DEF_WIDTH = 10;
    localparam int DEF_AW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_mem_array.sv
// -----------------------------------------------------------------------------
// word_mem_array
// DEPTH x WIDTH word storage with one synchronous write port, one
// combinational read port and an asynchronous clear of every word.
//
// Ports:
//   clk      in   write clock (rising edge)
//   rst      in   async active-high clear of all words
//   wr_en    in   write wr_data to wr_addr on this edge
//   wr_addr  in   write address (must be < DEPTH when wr_en=1)
//   wr_data  in   word to write
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr] when rd_addr < DEPTH, else 0
// -----------------------------------------------------------------------------
module word_mem_array
    import word_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // One extra bit so DEPTH itself is representable for the bound check.
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read is asynchronous, so a read of the address being written this
    // cycle returns the old word; the new word appears after the edge.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < DEPTH_X) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/word_ram_writer.sv
// -----------------------------------------------------------------------------
// word_ram_writer
// Loads DEPTH words into an internal word_mem_array after a start pulse,
// one word per in_valid && in_ready handshake, and flags done once the
// last address is written. The array can be read back at any time.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   async active-high reset (state, counters, memory)
//   start     in   one-cycle pulse: clear count, (re)begin a load
//   in_valid  in   in_data holds a word to store
//   in_data   in   word to store
//   in_ready  out  registered: high only while loading
//   wr_count  out  words stored since last start (0..DEPTH)
//   done      out  all DEPTH words stored
//   checksum  out  (only with WORD_RAM_WRITER_CHECKSUM_EN) mod-2^WIDTH sum
//                  of words accepted since last start/reset
//   rd_addr   in   readback address
//   rd_data   out  readback word (0 for rd_addr >= DEPTH)
//
// Optional feature macro: WORD_RAM_WRITER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module word_ram_writer
    import word_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [AW-1:0]    wr_count,
    output logic             done,
`ifdef WORD_RAM_WRITER_CHECKSUM_EN
    output logic [WIDTH-1:0] checksum,
`endif
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t state;
    logic   accept;

    // start wins over a simultaneous handshake: no write on a restart edge.
    assign accept = in_valid && in_ready && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_count <= '0;
            done     <= 1'b0;
            in_ready <= 1'b0;
        end else if (start) begin
            state    <= LOAD;
            wr_count <= '0;
            done     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        wr_count <= wr_count + AW'(1);
                        if (wr_count == LAST) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold; in_valid is ignored here.
                    state <= state;
                end
            endcase
        end
    end

`ifdef WORD_RAM_WRITER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + in_data;
        end
    end
`endif

    word_mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_count),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_word_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_word_ram_writer
// Directed bench for word_ram_writer (default geometry 10 x 10-bit, AW=4).
// Define WORD_RAM_WRITER_CHECKSUM_EN for both bench and RTL to include the
// checksum step.
// -----------------------------------------------------------------------------
module tb_word_ram_writer;

    localparam int DEPTH = 10;
    localparam int WIDTH = 10;
    localparam int AW    = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [AW-1:0]    wr_count;
    logic             done;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
`ifdef WORD_RAM_WRITER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    word_ram_writer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_count (wr_count),
        .done     (done),
`ifdef WORD_RAM_WRITER_CHECKSUM_EN
        .checksum (checksum),
`endif
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_addr  = '0;
        #1;
        check("reset_wr_count", 32'(wr_count), 32'd0);
        check("reset_done",     32'(done),     32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_rd_data",  32'(rd_data),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---- full load: words 0..9 with in_valid held high
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ready", 32'(in_ready), 32'd1);
        check("load_count0", 32'(wr_count), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = WIDTH'(i);
            tick();
            check("load_count", 32'(wr_count), 32'(i + 1));
            if (i == DEPTH - 2) check("load_done_early", 32'(done), 32'd0);
        end
        check("load_done", 32'(done), 32'd1);
        check("load_ready_off", 32'(in_ready), 32'd0);
        rd_addr = 4'd7;
        #1;
        check("load_rd7", 32'(rd_data), 32'h007);

        // in_valid ignored in DONE
        in_data = 10'h2AA;
        tick();
        check("done_ignore_count", 32'(wr_count), 32'd10);
        rd_addr = 4'd0;
        #1;
        check("done_ignore_mem0", 32'(rd_data), 32'h000);
        in_valid = 1'b0;

        // ---- gaps: in_valid high on even cycles only, 20 cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = WIDTH'(32'h100 + c);
            tick();
            check("gap_count", 32'(wr_count), 32'(c / 2 + 1));
        end
        in_valid = 1'b0;
        check("gap_done", 32'(done), 32'd1);
        rd_addr = 4'd3;
        #1;
        check("gap_rd3", 32'(rd_data), 32'h106);

        // ---- restart at wr_count=5 with a word presented
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = WIDTH'(32'h200 + i);
            tick();
        end
        check("restart_pre_count", 32'(wr_count), 32'd5);
        start   = 1'b1;
        in_data = 10'h3FF;
        tick();
        start = 1'b0;
        check("restart_count0", 32'(wr_count), 32'd0);
        rd_addr = 4'd5;
        #1;
        check("restart_mem5_kept", 32'(rd_data), 32'h10A);
        rd_addr = 4'd0;
        #1;
        check("restart_no_write", 32'(rd_data), 32'h200);
`ifdef WORD_RAM_WRITER_CHECKSUM_EN
        check("csum_cleared", 32'(checksum), 32'h000);
`endif
        tick();
        check("restart_count1", 32'(wr_count), 32'd1);
        check("restart_addr0", 32'(rd_data), 32'h3FF);
        in_data = 10'h002;
        tick();
        rd_addr = 4'd1;
        #1;
        check("restart_addr1", 32'(rd_data), 32'h002);
`ifdef WORD_RAM_WRITER_CHECKSUM_EN
        check("csum_wrap", 32'(checksum), 32'h001);
`endif

        // ---- readback bounds and same-cycle read/write hazard
        in_valid = 1'b0;
        rd_addr  = 4'd12;
        #1;
        check("rd_out_of_range", 32'(rd_data), 32'h000);
        rd_addr  = 4'd2;
        in_valid = 1'b1;
        in_data  = 10'h155;
        #1;
        check("hazard_old", 32'(rd_data), 32'h202);
        tick();
        in_valid = 1'b0;
        check("hazard_new", 32'(rd_data), 32'h155);

        // ---- reset mid-load after 4 words
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'(32'h300 + i);
            tick();
        end
        check("midrst_pre_count", 32'(wr_count), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_count", 32'(wr_count), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_done",  32'(done),     32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            check("midrst_mem", 32'(rd_data), 32'h000);
        end
        tick();
        rst = 1'b0;
        tick();
        // IDLE ignores in_valid
        check("idle_ignore_count", 32'(wr_count), 32'd0);
        rd_addr = 4'd0;
        #1;
        check("idle_ignore_mem", 32'(rd_data), 32'h000);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
